// File: rtl/jtag_host_master_pkg.sv
// jtag_host_master_pkg: shared JTAG host constants, DMI width defaults and scan state encoding
package jtag_host_master_pkg;
    localparam int DEF_ADDR_BITS = 6;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_OP_BITS   = 2;
    localparam int DR_BITS       = DEF_ADDR_BITS + DEF_DATA_BITS + DEF_OP_BITS;
    localparam int DEF_IR_BITS   = 5;
    localparam logic [4:0] IR_DMI_CODE   = 5'h11;
    localparam logic [4:0] IR_DTMCS_CODE = 5'h10;
    localparam int DEF_CLK_DIV   = 2;
    localparam int TLR_LEN       = 5;
    typedef enum logic [1:0] {
        S_TLR  = 2'd0,
        S_IDLE = 2'd1,
        S_IR   = 2'd2,
        S_DR   = 2'd3
    } state_t;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK and flags the clk edge on which TCK rises or falls
//   clk, rst_n     : system clock, synchronous active-low reset
//   run            : TCK toggles while high, parked at 0 while low
//   tck            : generated test clock
//   tck_rise/fall  : high in the cycle whose closing clk edge drives TCK to 1 / 0
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic wrap;

    // The divider idles at TOP so the first TCK rise follows run immediately.
    assign wrap     = run && cnt == TOP;
    assign tck_rise = wrap && !tck;
    assign tck_fall = wrap && tck;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= TOP;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/jtag_host_master.sv
// jtag_host_master: turns DMI requests into JTAG IR/DR scans and returns the shifted-out DR
//   clk, rst_n                          : system clock, synchronous active-low reset
//   req_valid_i/req_ready_o             : request handshake, ready only while idle
//   req_addr_i, req_data_i, req_op_i    : DMI request fields, shifted as {addr, data, op}
//   resp_valid_o, resp_data_o           : one-cycle completion pulse and captured DR
//   jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO : JTAG pins to the target TAP
module jtag_host_master
    import jtag_host_master_pkg::*;
#(
    parameter int DMI_ADDR_BITS = DEF_ADDR_BITS,
    parameter int DMI_DATA_BITS = DEF_DATA_BITS,
    parameter int DMI_OP_BITS   = DEF_OP_BITS,
    parameter int IR_BITS       = DEF_IR_BITS,
    parameter logic [IR_BITS-1:0] IR_DMI = IR_BITS'(IR_DMI_CODE),
    parameter int CLK_DIV       = DEF_CLK_DIV
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [DMI_ADDR_BITS-1:0] req_addr_i,
    input  logic [DMI_DATA_BITS-1:0] req_data_i,
    input  logic [DMI_OP_BITS-1:0]   req_op_i,
    output logic                     resp_valid_o,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] resp_data_o,
    output logic                     jtag_TCK,
    output logic                     jtag_TMS,
    output logic                     jtag_TDI,
    input  logic                     jtag_TDO
);
    localparam int DR_W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
    // Rise indices within each phase: last shifted bit and total rise count.
    localparam logic [5:0] TLR_N   = 6'(TLR_LEN);
    localparam logic [5:0] TLR_END = 6'(TLR_LEN + 1);
    localparam logic [5:0] IR_LAST = 6'(IR_BITS + 3);
    localparam logic [5:0] IR_END  = 6'(IR_BITS + 6);
    localparam logic [5:0] DR_LAST = 6'(DR_W + 2);
    localparam logic [5:0] DR_END  = 6'(DR_W + 5);

    state_t            state;
    logic [5:0]        bit_cnt;
    logic [DR_W-1:0]   shift_reg;
    logic              ir_loaded;
    logic              tck_rise;
    logic              tck_fall;
    logic [5:0]        phase_len;
    logic              dr_shift;
    logic              nxt_tms;
    logic              nxt_tdi;
    logic [IR_BITS-1:0] ir_sh;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != S_IDLE),
        .tck      (jtag_TCK),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // bit_cnt holds the index of the next TCK rise in the current phase, so the
    // TMS/TDI values prepared on a fall are the ones the target samples next.
    always_comb begin
        ir_sh     = IR_DMI >> (bit_cnt - 6'd4);
        phase_len = state == S_IR ? IR_END : state == S_DR ? DR_END : TLR_END;
        dr_shift  = state == S_DR && bit_cnt >= 6'd3 && bit_cnt <= DR_LAST;
        nxt_tms   = 1'b0;
        nxt_tdi   = 1'b0;
        if (state == S_TLR) begin
            nxt_tms = bit_cnt < TLR_N;
        end else if (state == S_IR) begin
            nxt_tms = bit_cnt < 6'd2 || bit_cnt == IR_LAST || bit_cnt == IR_LAST + 6'd1;
            nxt_tdi = bit_cnt >= 6'd4 && bit_cnt <= IR_LAST && ir_sh[0];
        end else if (state == S_DR) begin
            nxt_tms = bit_cnt == 6'd0 || bit_cnt == DR_LAST || bit_cnt == DR_LAST + 6'd1;
            nxt_tdi = dr_shift && shift_reg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_TLR;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            ir_loaded    <= 1'b0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            jtag_TMS     <= 1'b1;
            jtag_TDI     <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            if (state == S_IDLE) begin
                if (req_valid_i && req_ready_o) begin
                    shift_reg   <= {req_addr_i, req_data_i, req_op_i};
                    req_ready_o <= 1'b0;
                    bit_cnt     <= '0;
                    state       <= ir_loaded ? S_DR : S_IR;
                end
            end else if (tck_rise) begin
                bit_cnt <= bit_cnt + 6'd1;
                if (dr_shift)
                    shift_reg <= {jtag_TDO, shift_reg[DR_W-1:1]};
            end else if (tck_fall) begin
                if (bit_cnt == phase_len) begin
                    // Every phase starts with TMS=1 (Select-DR), so it is preset here
                    // while TCK is low and ready for the next phase's first rise.
                    bit_cnt  <= '0;
                    jtag_TMS <= 1'b1;
                    jtag_TDI <= 1'b0;
                    state    <= state == S_IR ? S_DR : S_IDLE;
                    if (state == S_IR)
                        ir_loaded <= 1'b1;
                    if (state == S_TLR)
                        ir_loaded <= 1'b0;
                    if (state != S_IR)
                        req_ready_o <= 1'b1;
                    if (state == S_DR) begin
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= shift_reg;
                    end
                end else begin
                    jtag_TMS <= nxt_tms;
                    jtag_TDI <= nxt_tdi;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_host_master.sv
// tb_jtag_host_master: drives DMI scans into jtag_host_master against a behavioural TAP target
module tb_jtag_host_master;
    localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3, T_SHDR = 4, T_EX1DR = 5,
                   T_PADR = 6, T_EX2DR = 7, T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10,
                   T_SHIR = 11, T_EX1IR = 12, T_PAIR = 13, T_EX2IR = 14, T_UPIR = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_op_i;
    logic        resp_valid_o;
    logic [39:0] resp_data_o;
    logic        jtag_TCK;
    logic        jtag_TMS;
    logic        jtag_TDI;
    logic        jtag_TDO = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    jtag_host_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_op_i     (req_op_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .jtag_TCK     (jtag_TCK),
        .jtag_TMS     (jtag_TMS),
        .jtag_TDI     (jtag_TDI),
        .jtag_TDO     (jtag_TDO)
    );

    always #5 clk = ~clk;

    // Behavioural IEEE 1149.1 TAP target, deliberately started away from Test-Logic-Reset.
    int          tap_st      = T_SHDR;
    logic [39:0] tap_dr      = '0;
    logic [39:0] tap_preload = '0;
    logic [39:0] tap_written = '0;
    logic [4:0]  tap_irsh    = '0;
    logic [4:0]  tap_ir      = '0;
    int          tap_updates = 0;

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            T_TLR:   return tms ? T_TLR   : T_RTI;
            T_RTI:   return tms ? T_SELDR : T_RTI;
            T_SELDR: return tms ? T_SELIR : T_CAPDR;
            T_CAPDR: return tms ? T_EX1DR : T_SHDR;
            T_SHDR:  return tms ? T_EX1DR : T_SHDR;
            T_EX1DR: return tms ? T_UPDR  : T_PADR;
            T_PADR:  return tms ? T_EX2DR : T_PADR;
            T_EX2DR: return tms ? T_UPDR  : T_SHDR;
            T_UPDR:  return tms ? T_SELDR : T_RTI;
            T_SELIR: return tms ? T_TLR   : T_CAPIR;
            T_CAPIR: return tms ? T_EX1IR : T_SHIR;
            T_SHIR:  return tms ? T_EX1IR : T_SHIR;
            T_EX1IR: return tms ? T_UPIR  : T_PAIR;
            T_PAIR:  return tms ? T_EX2IR : T_PAIR;
            T_EX2IR: return tms ? T_UPIR  : T_SHIR;
            T_UPIR:  return tms ? T_SELDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(posedge jtag_TCK) begin
        case (tap_st)
            T_TLR:   tap_ir = 5'h01;
            T_CAPDR: tap_dr = tap_preload;
            T_SHDR:  tap_dr = {jtag_TDI, tap_dr[39:1]};
            T_UPDR:  begin tap_written = tap_dr; tap_updates++; end
            T_CAPIR: tap_irsh = 5'b00001;
            T_SHIR:  tap_irsh = {jtag_TDI, tap_irsh[4:1]};
            T_UPIR:  tap_ir = tap_irsh;
            default: ;
        endcase
        tap_st = tap_next(tap_st, jtag_TMS);
    end

    always @(negedge jtag_TCK)
        jtag_TDO = tap_st == T_SHDR ? tap_dr[0] : tap_st == T_SHIR ? tap_irsh[0] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {TMS,TDI} presented at the k-th TCK rise of a request scan.
    function automatic logic [1:0] exp_edge(input bit with_ir, input logic [39:0] dr, input int k);
        logic [4:0] ir = 5'h11;
        if (with_ir) begin
            if (k < 2)   return 2'b10;
            if (k < 4)   return 2'b00;
            if (k < 9)   return {k == 8, ir[k-4]};
            if (k == 9)  return 2'b10;
            if (k == 10) return 2'b00;
            k -= 11;
        end
        if (k == 0)  return 2'b10;
        if (k < 3)   return 2'b00;
        if (k < 43)  return {k == 42, dr[k-3]};
        if (k == 43) return 2'b10;
        return 2'b00;
    endfunction

    int          rises, cyc, first_tck_cyc, pulses;
    bit          done;
    logic [63:0] o_tms, o_tdi;

    // Samples on negedge clk until ready is seen high, logging TMS/TDI at each TCK rise.
    task automatic collect(input int budget);
        logic prev_tck = jtag_TCK;
        rises = 0; cyc = 0; first_tck_cyc = -1; pulses = 0; done = 0;
        o_tms = '0; o_tdi = '0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (jtag_TCK && !prev_tck) begin
                if (rises < 64) begin
                    o_tms[rises] = jtag_TMS;
                    o_tdi[rises] = jtag_TDI;
                end
                if (first_tck_cyc < 0) first_tck_cyc = cyc;
                rises++;
            end
            prev_tck = jtag_TCK;
            if (resp_valid_o) pulses++;
            if (req_ready_o) done = 1;
        end
        chk("completes", done, 1);
    endtask

    task automatic check_tlr(input string tag);
        collect(400);
        chk({tag, "_rises"}, rises, 6);
        chk({tag, "_tms"}, o_tms[5:0], 6'b011111);
        chk({tag, "_no_resp"}, pulses, 0);
        chk({tag, "_ready_delay"}, (cyc - first_tck_cyc) >= 22 && (cyc - first_tck_cyc) <= 24, 1);
        chk({tag, "_tap_idle"}, tap_st, T_RTI);
    endtask

    task automatic do_scan(input bit with_ir, input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] o, input logic [39:0] pre);
        logic [63:0] et = '0, ed = '0;
        logic [1:0]  e;
        int          n = with_ir ? 56 : 45;
        int          upd0 = tap_updates;
        for (int k = 0; k < n; k++) begin
            e = exp_edge(with_ir, {a, d, o}, k);
            et[k] = e[1];
            ed[k] = e[0];
        end
        tap_preload = pre;
        chk("ready_before", req_ready_o, 1);
        req_addr_i = a; req_data_i = d; req_op_i = o; req_valid_i = 1'b1;
        collect(n * 4 + 60);
        req_valid_i = 1'b0;
        chk("rises", rises, n);
        chk("tms_seq", o_tms, et);
        chk("tdi_seq", o_tdi, ed);
        chk("resp_pulse", resp_valid_o, 1);
        chk("pulses", pulses, 1);
        chk("resp_data", resp_data_o, pre);
        if (!with_ir) chk("latency", cyc >= 179 && cyc <= 181, 1);
        @(negedge clk);
        chk("pulse_width", resp_valid_o, 0);
        chk("resp_hold", resp_data_o, pre);
        chk("ready_after", req_ready_o, 1);
        chk("tap_ir", tap_ir, 5'h11);
        chk("tap_dr_in", tap_written, {a, d, o});
        chk("one_update", tap_updates - upd0, 1);
    endtask

    initial begin
        logic [5:0]  ra;
        logic [31:0] rd;
        logic [1:0]  ro;
        logic [39:0] rp;
        int          hi, r;
        logic        prev;
        rst_n = 1'b0; req_valid_i = 1'b0;
        req_addr_i = '0; req_data_i = '0; req_op_i = '0;
        repeat (4) @(negedge clk);
        chk("rst_tck", jtag_TCK, 0);
        chk("rst_tms", jtag_TMS, 1);
        chk("rst_tdi", jtag_TDI, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        rst_n = 1'b1;
        check_tlr("tlr");

        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (jtag_TCK) hi++;
        end
        chk("tck_parked", hi, 0);

        do_scan(1, 6'h10, 32'hDEADBEEF, 2'd2, {6'h04, 32'hCAFEF00D, 2'b00});
        for (int i = 0; i < 3; i++) begin
            ra = 6'($urandom); rd = $urandom; ro = 2'($urandom); rp = {8'($urandom), 32'($urandom)};
            do_scan(0, ra, rd, ro, rp);
        end

        // Reset pulse while DR bit 20 is on the wire.
        ra = 6'($urandom); rd = $urandom; ro = 2'($urandom);
        tap_preload = {8'($urandom), 32'($urandom)};
        req_addr_i = ra; req_data_i = rd; req_op_i = ro; req_valid_i = 1'b1;
        r = 0; prev = jtag_TCK;
        for (int k = 0; k < 400 && r < 24; k++) begin
            @(negedge clk);
            if (jtag_TCK && !prev) r++;
            prev = jtag_TCK;
        end
        chk("reach_bit20", r, 24);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req_valid_i = 1'b0;
        chk("mid_rst_tck", jtag_TCK, 0);
        chk("mid_rst_tms", jtag_TMS, 1);
        chk("mid_rst_ready", req_ready_o, 0);
        chk("mid_rst_resp_valid", resp_valid_o, 0);
        chk("mid_rst_resp_data", resp_data_o, 0);
        check_tlr("tlr2");

        ra = 6'($urandom); rd = $urandom; ro = 2'($urandom); rp = {8'($urandom), 32'($urandom)};
        do_scan(1, ra, rd, ro, rp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
